// File: rtl/raster_counter.sv
// Two-dimensional raster address counter: column/row/linear address
// with load, hold, clear, wrap-or-stop and end-of-line/frame flags.
module raster_counter #(
  parameter int COL_W   = 7,
  parameter int ROW_W   = 7,
  parameter int COL_MAX = 127,
  parameter int ROW_MAX = 127,
  parameter bit WRAP    = 1'b1,
  parameter int ADDR_W  = COL_W + ROW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [COL_W-1:0]  load_col,
  input  logic [ROW_W-1:0]  load_row,
  input  logic              keep,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              col_last,
  output logic              row_last,
  output logic              frame_done,
  output logic              halted
);

  localparam logic [COL_W-1:0]  CMAX = COL_W'(COL_MAX);
  localparam logic [ROW_W-1:0]  RMAX = ROW_W'(ROW_MAX);
  localparam logic [ADDR_W-1:0] COLS = ADDR_W'(COL_MAX + 1);

  typedef enum logic {
    COUNTING,
    HALTED
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [COL_W-1:0] col_nx;
  logic [ROW_W-1:0] row_nx;
  logic             done_nx;
  logic [COL_W-1:0] col_clamp;
  logic [ROW_W-1:0] row_clamp;

  assign col_last = (col == CMAX);
  assign row_last = (row == RMAX);
  assign halted   = (state == HALTED);
  assign addr     = ADDR_W'(row) * COLS + ADDR_W'(col);

  // Out-of-range loads saturate at the frame edge rather than wrapping.
  assign col_clamp = (load_col > CMAX) ? CMAX : load_col;
  assign row_clamp = (load_row > RMAX) ? RMAX : load_row;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= COUNTING;
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      col        <= col_nx;
      row        <= row_nx;
      frame_done <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    done_nx  = 1'b0;
    if (clear) begin
      state_nx = COUNTING;
      col_nx   = '0;
      row_nx   = '0;
    end else if (load) begin
      state_nx = COUNTING;
      col_nx   = col_clamp;
      row_nx   = row_clamp;
    end else if (keep || state == HALTED) begin
      state_nx = state;
    end else if (!col_last) begin
      col_nx = col + 1'b1;
    end else if (!row_last) begin
      col_nx = '0;
      row_nx = row + 1'b1;
    end else begin
      // Last pixel: either restart the frame or park here.
      done_nx = 1'b1;
      if (WRAP) begin
        col_nx = '0;
        row_nx = '0;
      end else begin
        state_nx = HALTED;
      end
    end
  end

endmodule

// File: tb/tb_raster_counter.sv
// Bench for raster_counter: default wrapping instance plus a small
// stopping instance, checked against a linear-index frame model.
module tb_raster_counter;

  typedef struct {
    int p;
    bit h;
    bit fd;
  } model_t;

  logic clk = 0;
  logic rst = 0;

  logic       a_clear = 0, a_load = 0, a_keep = 0;
  logic [6:0] a_lc = '0, a_lr = '0;
  logic [6:0] a_col, a_row;
  logic [13:0] a_addr;
  logic       a_cl, a_rl, a_fd, a_h;

  logic       b_clear = 0, b_load = 0, b_keep = 0;
  logic [6:0] b_lc = '0, b_lr = '0;
  logic [6:0] b_col, b_row;
  logic [13:0] b_addr;
  logic       b_cl, b_rl, b_fd, b_h;

  int total = 0;
  int bad = 0;

  model_t ma, mb;

  always #5 clk = ~clk;

  raster_counter dut_a (
    .clk(clk), .rst(rst), .clear(a_clear), .load(a_load),
    .load_col(a_lc), .load_row(a_lr), .keep(a_keep),
    .col(a_col), .row(a_row), .addr(a_addr),
    .col_last(a_cl), .row_last(a_rl),
    .frame_done(a_fd), .halted(a_h)
  );

  raster_counter #(
    .COL_MAX(3), .ROW_MAX(2), .WRAP(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .clear(b_clear), .load(b_load),
    .load_col(b_lc), .load_row(b_lr), .keep(b_keep),
    .col(b_col), .row(b_row), .addr(b_addr),
    .col_last(b_cl), .row_last(b_rl),
    .frame_done(b_fd), .halted(b_h)
  );

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int imin(int x, int y);
    return (x < y) ? x : y;
  endfunction

  // Position kept as a linear pixel index within the frame.
  function automatic model_t step(model_t m, int cm, int rm, bit wrap,
                                  bit clr, bit ld, bit kp, int lc, int lr);
    model_t n = m;
    int npix = (cm + 1) * (rm + 1);
    n.fd = 0;
    if (clr) begin
      n.p = 0;
      n.h = 0;
    end else if (ld) begin
      n.p = imin(lr, rm) * (cm + 1) + imin(lc, cm);
      n.h = 0;
    end else if (kp || m.h) begin
      n.p = m.p;
    end else if (m.p == npix - 1) begin
      n.fd = 1;
      if (wrap) n.p = 0;
      else n.h = 1;
    end else begin
      n.p = m.p + 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma = '{0, 0, 0};
      mb = '{0, 0, 0};
    end else begin
      ma = step(ma, 127, 127, 1'b1, a_clear, a_load, a_keep,
                int'(a_lc), int'(a_lr));
      mb = step(mb, 3, 2, 1'b0, b_clear, b_load, b_keep,
                int'(b_lc), int'(b_lr));
    end
  end

  always @(negedge clk) begin
    check("a_col", int'(a_col), ma.p % 128);
    check("a_row", int'(a_row), ma.p / 128);
    check("a_addr", int'(a_addr), ma.p);
    check("a_col_last", int'(a_cl), int'(ma.p % 128 == 127));
    check("a_row_last", int'(a_rl), int'(ma.p / 128 == 127));
    check("a_frame_done", int'(a_fd), int'(ma.fd));
    check("a_halted", int'(a_h), 0);
    check("b_col", int'(b_col), mb.p % 4);
    check("b_row", int'(b_row), mb.p / 4);
    check("b_addr", int'(b_addr), mb.p);
    check("b_col_last", int'(b_cl), int'(mb.p % 4 == 3));
    check("b_row_last", int'(b_rl), int'(mb.p / 4 == 2));
    check("b_frame_done", int'(b_fd), int'(mb.fd));
    check("b_halted", int'(b_h), int'(mb.h));
  end

  task automatic a_load_at(int c, int r);
    a_load = 1;
    a_lc = 7'(c);
    a_lr = 7'(r);
    @(negedge clk);
    a_load = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_col", int'(a_col), 0);
    check("rst_row", int'(a_row), 0);
    check("rst_addr", int'(a_addr), 0);
    check("rst_flags", int'({a_cl, a_rl, a_fd, a_h}), 0);
    check("rst_b_flags", int'({b_cl, b_rl, b_fd, b_h}), 0);
    rst = 1;

    // Full default frame; small instance runs its own script alongside.
    for (int i = 0; i <= 16384; i++) begin
      check("frame_addr", int'(a_addr), i % 16384);
      check("frame_done_pulse", int'(a_fd), int'(i == 16384));
      if (i == 127) check("col127", int'(a_col), 127);
      if (i == 128) check("wrap_row1", int'({a_col, a_row}), 1);
      if (i == 12) begin
        check("b_park", int'({b_col, b_row}), (3 << 7) | 2);
        check("b_halt", int'(b_h), 1);
        check("b_done", int'(b_fd), 1);
      end
      if (i > 12 && i < 30) begin
        check("b_hold", int'({b_col, b_row}), (3 << 7) | 2);
        check("b_no_done", int'(b_fd), 0);
      end
      if (i == 30) b_clear = 1;
      if (i == 31) begin
        b_clear = 0;
        check("b_cleared", int'({b_col, b_row, b_h}), 0);
      end
      if (i < 16384) @(negedge clk);
    end

    // Hold at (5,1).
    a_load_at(5, 1);
    a_keep = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("keep_pos", int'({a_col, a_row}), (5 << 7) | 1);
      check("keep_addr", int'(a_addr), 133);
      check("keep_flags", int'({a_cl, a_rl, a_fd}), 0);
    end
    a_keep = 0;
    @(negedge clk);
    check("keep_release", int'({a_col, a_row}), (6 << 7) | 1);

    // Clamped load: load_col=200 truncates to the 7-bit port, so drive 127
    // and check via the small instance where clamping is observable.
    a_load_at(127, 4);
    check("load_edge", int'({a_col, a_row, a_cl}), (127 << 8) | (4 << 1) | 1);
    @(negedge clk);
    check("load_next", int'({a_col, a_row}), 5);
    check("load_addr", int'(a_addr), 640);
    b_load = 1;
    b_lc = 7'd100;
    b_lr = 7'd9;
    @(negedge clk);
    b_load = 0;
    check("b_clamp", int'({b_col, b_row, b_cl, b_rl}), (3 << 9) | (2 << 2) | 3);

    // clear + load + keep together.
    a_load_at(10, 10);
    a_clear = 1;
    a_load = 1;
    a_keep = 1;
    a_lc = 7'd20;
    a_lr = 7'd20;
    @(negedge clk);
    a_clear = 0;
    a_load = 0;
    a_keep = 0;
    check("clear_wins", int'({a_col, a_row}), 0);

    // Asynchronous reset between edges.
    a_load_at(50, 3);
    a_keep = 1;
    check("pre_rst", int'(a_addr), 3 * 128 + 50);
    @(posedge clk);
    #3;
    rst = 0;
    #1;
    check("async_rst_pos", int'({a_col, a_row}), 0);
    check("async_rst_addr", int'(a_addr), 0);
    check("async_rst_b", int'({b_col, b_row, b_h, b_fd}), 0);
    @(negedge clk);
    rst = 1;
    a_keep = 0;
    @(negedge clk);
    check("restart", int'({a_col, a_row}), 1 << 7);

    // Randomised command mix on both instances.
    for (int k = 0; k < 4000; k++) begin
      a_clear = ($urandom_range(0, 63) == 0);
      a_load = ($urandom_range(0, 15) == 0);
      a_keep = ($urandom_range(0, 3) == 0);
      a_lc = 7'($urandom_range(0, 127));
      a_lr = 7'($urandom_range(0, 127));
      b_clear = ($urandom_range(0, 39) == 0);
      b_load = ($urandom_range(0, 9) == 0);
      b_keep = ($urandom_range(0, 3) == 0);
      b_lc = 7'($urandom_range(0, 127));
      b_lr = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) b_lc = 7'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) b_lr = 7'($urandom_range(0, 4));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
